// File: rtl/ufm_req_arb_if.sv
// Handshake bundle between the requesters/UFM engine and the arbiter.
// The arbiter connects through the slave modport; whatever drives the
// requests and the engine status connects through the master modport.
interface ufm_req_arb_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] req_in;
  logic               ufm_busy;
  logic               ufm_done;
  logic               err_clr;
  logic [NUM_REQ-1:0] grant;
  logic               ufm_start;
  logic [NUM_REQ-1:0] ack;
  logic               timeout_err;

  modport slave (
    input  req_in, ufm_busy, ufm_done, err_clr,
    output grant, ufm_start, ack, timeout_err
  );

  modport master (
    output req_in, ufm_busy, ufm_done, err_clr,
    input  grant, ufm_start, ack, timeout_err
  );
endinterface

// File: rtl/ufm_req_arb.sv
// Round-robin arbiter sharing one UFM page engine between NUM_REQ
// asynchronous four-phase requesters. Requests are double-flopped under
// the clock enable, the winner gets a one-cycle ufm_start, the engine's
// done pulse (or a timeout abort) turns into a level ack, and the grant
// is released once the winner drops its request.
module ufm_req_arb #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic            sync_clk,
  input  logic            sync_rst_n,
  input  logic            sync_clk_en,
  ufm_req_arb_if.slave    bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    ACK       = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_s0;
  logic [NUM_REQ-1:0] r_s1;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_start;
  logic               r_err;
  logic               r_done_pend;
  logic [CNT_W-1:0]   r_cnt;
  logic [IW-1:0]      r_ptr;

  logic [IW-1:0]      w_winner;
  logic               w_found;
  int                 w_idx;
  logic               w_done_hit;
  logic               w_timeout;
  logic               w_leave_wait;

  // A done pulse seen now or remembered from a disabled edge both count.
  assign w_done_hit   = bus.ufm_done | r_done_pend;
  assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_leave_wait = sync_clk_en && (r_state == WAIT_DONE) &&
                        (w_done_hit || w_timeout);

  // Two-stage synchronizer per request bit; stages hold while disabled.
  always_ff @(posedge sync_clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      r_s0 <= '0;
      r_s1 <= '0;
    end else if (sync_clk_en) begin
      r_s1 <= r_s0;
      r_s0 <= bus.req_in;
    end
  end

  // Round-robin search: first synchronized request after the last winner.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && r_s1[w_idx[IW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[IW-1:0];
      end
    end
  end

  // Catch done pulses on every edge so none are lost while disabled;
  // consuming the pulse when leaving WAIT_DONE takes priority so a stale
  // pending flag never completes the next transaction early.
  always_ff @(posedge sync_clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      r_done_pend <= 1'b0;
    end else if (w_leave_wait) begin
      r_done_pend <= 1'b0;
    end else if (bus.ufm_done) begin
      r_done_pend <= 1'b1;
    end
  end

  // Arbitration/handshake FSM; ufm_start and err_clr act on every edge,
  // everything else only on enabled edges. An abort set beats a clear.
  always_ff @(posedge sync_clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ack   <= '0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= IW'(NUM_REQ - 1);
    end else begin
      r_start <= 1'b0;
      if (bus.err_clr) begin
        r_err <= 1'b0;
      end
      if (sync_clk_en) begin
        case (r_state)
          IDLE: begin
            if (w_found && !bus.ufm_busy) begin
              r_grant <= NUM_REQ'(1) << w_winner;
              r_ptr   <= w_winner;
              r_cnt   <= '0;
              r_start <= 1'b1;
              r_state <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (w_done_hit) begin
              r_ack   <= r_grant;
              r_state <= ACK;
            end else if (w_timeout) begin
              r_ack   <= r_grant;
              r_err   <= 1'b1;
              r_state <= ACK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ACK: begin
            if (!r_s1[r_ptr]) begin
              r_ack   <= '0;
              r_grant <= '0;
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.grant       = r_grant;
  assign bus.ack         = r_ack;
  assign bus.ufm_start   = r_start;
  assign bus.timeout_err = r_err;

endmodule

// File: tb/tb_ufm_req_arb.sv
// Directed bench for ufm_req_arb: one instance with the default timeout
// for latency, contention, busy, enable-gating, reset and glitch cases,
// and one with TIMEOUT=4 for abort / error-flag behaviour.
module tb_ufm_req_arb;

  logic clk = 1'b0;
  logic rstN;
  logic enA;
  logic enT;
  int   nChecks = 0;
  int   nPass   = 0;

  ufm_req_arb_if #(.NUM_REQ(2)) busA ();
  ufm_req_arb_if #(.NUM_REQ(2)) busT ();

  ufm_req_arb #(.NUM_REQ(2), .CNT_W(10), .TIMEOUT(1000)) dutA (
    .sync_clk    (clk),
    .sync_rst_n  (rstN),
    .sync_clk_en (enA),
    .bus         (busA)
  );

  ufm_req_arb #(.NUM_REQ(2), .CNT_W(3), .TIMEOUT(4)) dutT (
    .sync_clk    (clk),
    .sync_rst_n  (rstN),
    .sync_clk_en (enT),
    .bus         (busT)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Hard stop in case something wedges the stimulus thread.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input bit toT, input logic [1:0] req, input logic busy,
                               input logic done, input logic clr);
    if (toT) begin
      busT.req_in = req; busT.ufm_busy = busy; busT.ufm_done = done; busT.err_clr = clr;
    end else begin
      busA.req_in = req; busA.ufm_busy = busy; busA.ufm_done = done; busA.err_clr = clr;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] getGrant(input bit toT);
    return toT ? busT.grant : busA.grant;
  endfunction

  task automatic waitGrant(input bit toT, input string tag);
    int n = 0;
    while (getGrant(toT) == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    if (getGrant(toT) == 2'b00) checkOutput({tag, "_bound"}, 0, 1);
  endtask

  task automatic waitIdle(input bit toT, input string tag);
    int n = 0;
    while (getGrant(toT) != 2'b00 && n < 20) begin
      tick();
      n++;
    end
    if (getGrant(toT) != 2'b00) checkOutput({tag, "_bound"}, 0, 1);
  endtask

  task automatic resetDut();
    applyStimulus(0, 2'b00, 1'b0, 1'b0, 1'b0);
    rstN = 1'b0;
    #2;
    rstN = 1'b1;
    tick();
  endtask

  initial begin
    rstN = 1'b0;
    enA  = 1'b1;
    enT  = 1'b1;
    applyStimulus(0, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rst_grant", 32'(busA.grant), 0);
    checkOutput("rst_ack", 32'(busA.ack), 0);
    checkOutput("rst_start", 32'(busA.ufm_start), 0);
    checkOutput("rst_err", 32'(busA.timeout_err), 0);
    tick();
    rstN = 1'b1;

    // Single request latency with enable high.
    applyStimulus(0, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t1_e1_grant", 32'(busA.grant), 0);
    tick();
    tick();
    checkOutput("t1_e3_grant", 32'(busA.grant), 1);
    checkOutput("t1_e3_start", 32'(busA.ufm_start), 1);
    tick();
    checkOutput("t1_e4_start", 32'(busA.ufm_start), 0);
    checkOutput("t1_e4_grant", 32'(busA.grant), 1);
    repeat (5) tick();
    checkOutput("t1_e9_ack", 32'(busA.ack), 0);
    applyStimulus(0, 2'b01, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(0, 2'b01, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_e10_ack", 32'(busA.ack), 1);
    tick();
    checkOutput("t1_e11_ack", 32'(busA.ack), 1);
    applyStimulus(0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("t1_e12_grant", 32'(busA.grant), 1);
    tick();
    tick();
    checkOutput("t1_rel_grant", 32'(busA.grant), 0);
    checkOutput("t1_rel_ack", 32'(busA.ack), 0);

    // Contention: both requesting, grants must alternate from requester 0.
    resetDut();
    applyStimulus(0, 2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      int expG;
      expG = (i % 2 == 0) ? 1 : 2;
      waitGrant(0, $sformatf("cont%0d", i));
      checkOutput($sformatf("cont%0d_grant", i), 32'(busA.grant), expG);
      applyStimulus(0, 2'b11, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(0, 2'b11, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("cont%0d_ack", i), 32'(busA.ack), expG);
      applyStimulus(0, 2'(3 & ~expG), 1'b0, 1'b0, 1'b0);
      waitIdle(0, $sformatf("cont%0d_idle", i));
      applyStimulus(0, 2'b11, 1'b0, 1'b0, 1'b0);
    end

    // Busy engine blocks grants until it frees up.
    resetDut();
    applyStimulus(0, 2'b01, 1'b1, 1'b0, 1'b0);
    repeat (6) tick();
    checkOutput("busy_grant", 32'(busA.grant), 0);
    checkOutput("busy_start", 32'(busA.ufm_start), 0);
    applyStimulus(0, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("unbusy_grant", 32'(busA.grant), 1);
    checkOutput("unbusy_start", 32'(busA.ufm_start), 1);
    applyStimulus(0, 2'b01, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("unbusy_ack", 32'(busA.ack), 1);
    waitIdle(0, "unbusy_idle");

    // Enable toggling 1,0,1,0 with a done pulse landing on a disabled edge.
    resetDut();
    applyStimulus(0, 2'b01, 1'b0, 1'b0, 1'b0);
    enA = 1'b1; tick();
    enA = 1'b0; tick();
    enA = 1'b1; tick();
    checkOutput("gate_e3_grant", 32'(busA.grant), 0);
    enA = 1'b0; tick();
    enA = 1'b1; tick();
    checkOutput("gate_e5_grant", 32'(busA.grant), 1);
    checkOutput("gate_e5_start", 32'(busA.ufm_start), 1);
    enA = 1'b0; tick();
    checkOutput("gate_e6_start", 32'(busA.ufm_start), 0);
    enA = 1'b1; tick();
    enA = 1'b0;
    applyStimulus(0, 2'b01, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(0, 2'b01, 1'b0, 1'b0, 1'b0);
    checkOutput("gate_e8_ack", 32'(busA.ack), 0);
    enA = 1'b1; tick();
    checkOutput("gate_e9_ack", 32'(busA.ack), 1);
    applyStimulus(0, 2'b00, 1'b0, 1'b0, 1'b0);
    waitIdle(0, "gate_idle");

    // Glitches: one pulse entirely between edges, one seen only by a disabled edge.
    resetDut();
    applyStimulus(0, 2'b01, 1'b0, 1'b0, 1'b0);
    #2;
    applyStimulus(0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    enA = 1'b0;
    applyStimulus(0, 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(0, 2'b00, 1'b0, 1'b0, 1'b0);
    enA = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("glitch%0d_grant", i), 32'(busA.grant), 0);
      checkOutput($sformatf("glitch%0d_start", i), 32'(busA.ufm_start), 0);
    end

    // Timeout instance: abort after four WAIT_DONE edges.
    applyStimulus(1, 2'b01, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("to1_grant", 32'(busT.grant), 1);
    repeat (3) tick();
    checkOutput("to1_e6_ack", 32'(busT.ack), 0);
    checkOutput("to1_e6_err", 32'(busT.timeout_err), 0);
    tick();
    checkOutput("to1_e7_ack", 32'(busT.ack), 1);
    checkOutput("to1_e7_err", 32'(busT.timeout_err), 1);
    applyStimulus(1, 2'b01, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1, 2'b01, 1'b0, 1'b0, 1'b0);
    checkOutput("to1_clr_err", 32'(busT.timeout_err), 0);
    applyStimulus(1, 2'b00, 1'b0, 1'b0, 1'b0);
    waitIdle(1, "to1_idle");

    // Done on the same edge as the timeout completes normally.
    applyStimulus(1, 2'b01, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("to2_grant", 32'(busT.grant), 1);
    repeat (3) tick();
    applyStimulus(1, 2'b01, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1, 2'b01, 1'b0, 1'b0, 1'b0);
    checkOutput("to2_ack", 32'(busT.ack), 1);
    checkOutput("to2_err", 32'(busT.timeout_err), 0);
    applyStimulus(1, 2'b00, 1'b0, 1'b0, 1'b0);
    waitIdle(1, "to2_idle");

    // Clear coinciding with a new abort: the set wins.
    applyStimulus(1, 2'b01, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("to3_grant", 32'(busT.grant), 1);
    repeat (3) tick();
    applyStimulus(1, 2'b01, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1, 2'b01, 1'b0, 1'b0, 1'b0);
    checkOutput("to3_ack", 32'(busT.ack), 1);
    checkOutput("to3_err", 32'(busT.timeout_err), 1);

    // Reset in the start cycle clears everything asynchronously.
    applyStimulus(0, 2'b11, 1'b0, 1'b0, 1'b0);
    waitGrant(0, "rmid");
    checkOutput("rmid_pre_start", 32'(busA.ufm_start), 1);
    rstN = 1'b0;
    #1;
    checkOutput("rmid_grant", 32'(busA.grant), 0);
    checkOutput("rmid_ack", 32'(busA.ack), 0);
    checkOutput("rmid_start", 32'(busA.ufm_start), 0);
    checkOutput("rmid_t_err", 32'(busT.timeout_err), 0);
    checkOutput("rmid_t_grant", 32'(busT.grant), 0);
    #2;
    rstN = 1'b1;
    tick();
    waitGrant(0, "rpost");
    checkOutput("rpost_grant", 32'(busA.grant), 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
